output_drain: RTL and testbench

Reader-side drain engine for the output buffer. On a start pulse it sweeps the buffer read select from entry 0 to entry BUF_NUM-1 and captures each combinational read result. It then emits the entries as a valid/ready stream toward the result writeback path, with a last flag and a done pulse. While a drain is in progress it asserts busy so the accumulation path holds off writes.

---
 rtl/output_drain.sv | 115 +++++++++++
 tb/tb_output_drain.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/output_drain.sv
// Output buffer drain: sweeps read select 0..BUF_NUM-1, streams captured entries out with last/done; 1 cycle start-to-first-valid.
// Stalls hold idx and the output register without a bubble; optional ReLU clamp on capture via OUTPUT_DRAIN_RELU_EN.
`ifndef OUTPUT_BUF_NUM
`define OUTPUT_BUF_NUM 4
`endif
`ifndef PARTIAL_OUT_SIZE
`define PARTIAL_OUT_SIZE 16
`endif

module output_drain #(
    parameter int BUF_NUM = `OUTPUT_BUF_NUM,
    parameter int DAT_W   = `PARTIAL_OUT_SIZE
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [$clog2(BUF_NUM)-1:0] out_sel_o,
    input  logic [DAT_W-1:0]           out_dat_i,
    output logic                       res_val_o,
    input  logic                       res_rdy_i,
    output logic [DAT_W-1:0]           res_dat_o,
    output logic                       res_last_o
);

    localparam int IDX_W = $clog2(BUF_NUM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUF_NUM - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             val_nxt, last_nxt;
    logic [DAT_W-1:0] dat_nxt;
    logic             load;

    function automatic logic [DAT_W-1:0] xform(input logic [DAT_W-1:0] x);
`ifdef OUTPUT_DRAIN_RELU_EN
        xform = x[DAT_W-1] ? '0 : x;
`else
        xform = x;
`endif
    endfunction

    // An empty output register or a consuming sink lets the next entry in.
    assign load = !res_val_o || res_rdy_i;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        val_nxt   = res_val_o;
        dat_nxt   = res_dat_o;
        last_nxt  = res_last_o;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_nxt = ST_RUN;
                    idx_nxt   = '0;
                end
            end
            ST_RUN: begin
                if (load) begin
                    dat_nxt  = xform(out_dat_i);
                    val_nxt  = 1'b1;
                    last_nxt = (idx == LAST_IDX);
                    if (idx == LAST_IDX) begin
                        state_nxt = ST_FLUSH;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (res_val_o && res_rdy_i) begin
                    val_nxt   = 1'b0;
                    last_nxt  = 1'b0;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            idx        <= '0;
            res_val_o  <= 1'b0;
            res_dat_o  <= '0;
            res_last_o <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            res_val_o  <= val_nxt;
            res_dat_o  <= dat_nxt;
            res_last_o <= last_nxt;
        end
    end

    assign busy_o    = (state != ST_IDLE);
    assign done_o    = (state == ST_DONE);
    assign out_sel_o = (state == ST_IDLE) ? '0 : idx;

endmodule

// File: tb/tb_output_drain.sv
// Bench for output_drain: directed vector table, hand-written reset/restart sequence, randomized drains vs. a beat-list model.
module tb_output_drain;

    localparam int BN = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done;
    logic [1:0]    out_sel;
    logic [DW-1:0] out_dat;
    logic          res_val, res_rdy, res_last;
    logic [DW-1:0] res_dat;
    logic [DW-1:0] mem [BN];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign out_dat = mem[out_sel];

    output_drain #(.BUF_NUM(BN), .DAT_W(DW)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .busy_o    (busy),
        .done_o    (done),
        .out_sel_o (out_sel),
        .out_dat_i (out_dat),
        .res_val_o (res_val),
        .res_rdy_i (res_rdy),
        .res_dat_o (res_dat),
        .res_last_o(res_last)
    );

    typedef struct {
        logic          st;
        logic          rdy;
        logic          v;
        logic [DW-1:0] d;
        logic          l;
        logic          dn;
        logic          b;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [DW-1:0] tf(input logic [DW-1:0] x);
`ifdef OUTPUT_DRAIN_RELU_EN
        return x[DW-1] ? 16'h0000 : x;
`else
        return x;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] hd;
        logic          hl, held, got_done;
        int            cyc, stalls, beat;

        // st rdy | val dat last done busy
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 16'h0011, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 16'h8002, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 16'h0033, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 16'h0011, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 16'h8002, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 16'h8002, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 16'h8002, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 16'h0033, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};

        mem[0] = 16'h0011; mem[1] = 16'h8002; mem[2] = 16'h0033; mem[3] = 16'hFFFF;
        rst = 1'b1; start = 1'b0; res_rdy = 1'b0;
        tick(); tick();
        chk("reset val",  {31'b0, res_val},  32'd0);
        chk("reset busy", {31'b0, busy},     32'd0);
        chk("reset done", {31'b0, done},     32'd0);
        chk("reset sel",  {30'b0, out_sel},  32'd0);
        chk("reset dat",  {16'b0, res_dat},  32'd0);
        #2 rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            start   = tbl[i].st;
            res_rdy = tbl[i].rdy;
            tick();
            chk($sformatf("row%0d val", i),  {31'b0, res_val},  {31'b0, tbl[i].v});
            chk($sformatf("row%0d done", i), {31'b0, done},     {31'b0, tbl[i].dn});
            chk($sformatf("row%0d busy", i), {31'b0, busy},     {31'b0, tbl[i].b});
            if (tbl[i].v) begin
                chk($sformatf("row%0d dat", i),  {16'b0, res_dat}, {16'b0, tf(tbl[i].d)});
                chk($sformatf("row%0d last", i), {31'b0, res_last}, {31'b0, tbl[i].l});
            end
        end
        start = 1'b0;

        // Reset between beats 1 and 2, then a fresh drain must restart at entry 0.
        res_rdy = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        chk("pre-rst beat1", {16'b0, res_dat}, {16'b0, tf(16'h8002)});
        #2 rst = 1'b1;
        #1;
        chk("async rst val",  {31'b0, res_val},  32'd0);
        chk("async rst last", {31'b0, res_last}, 32'd0);
        chk("async rst dat",  {16'b0, res_dat},  32'd0);
        chk("async rst busy", {31'b0, busy},     32'd0);
        chk("async rst done", {31'b0, done},     32'd0);
        chk("async rst sel",  {30'b0, out_sel},  32'd0);
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post-rst idle busy", {31'b0, busy}, 32'd0);
            chk("post-rst idle val",  {31'b0, res_val}, 32'd0);
        end
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < BN; k++) begin
            tick();
            chk($sformatf("restart beat%0d val", k),  {31'b0, res_val}, 32'd1);
            chk($sformatf("restart beat%0d dat", k),  {16'b0, res_dat}, {16'b0, tf(mem[k])});
            chk($sformatf("restart beat%0d last", k), {31'b0, res_last}, {31'b0, k == BN - 1});
        end
        tick();
        chk("restart done", {31'b0, done}, 32'd1);
        tick();

        // Randomized drains: beats must equal f(mem[0..3]) in order, done after BN+1 edges plus one per stall.
        for (int d = 0; d < 20; d++) begin
            for (int j = 0; j < BN; j++) mem[j] = DW'($urandom);
            start = 1'b1;
            res_rdy = 1'($urandom_range(0, 1));
            tick();
            chk($sformatf("rnd%0d busy", d), {31'b0, busy}, 32'd1);
            cyc = 0; stalls = 0; beat = 0; got_done = 1'b0; held = 1'b0;
            hd = '0; hl = 1'b0;
            while (!got_done && cyc < 200) begin
                start   = ($urandom_range(0, 3) == 0);
                res_rdy = ($urandom_range(0, 2) != 0);
                if (held) begin
                    chk($sformatf("rnd%0d hold val", d),  {31'b0, res_val},  32'd1);
                    chk($sformatf("rnd%0d hold dat", d),  {16'b0, res_dat},  {16'b0, hd});
                    chk($sformatf("rnd%0d hold last", d), {31'b0, res_last}, {31'b0, hl});
                end
                held = 1'b0;
                if (res_val && res_rdy) begin
                    if (beat < BN) begin
                        chk($sformatf("rnd%0d beat%0d dat", d, beat),  {16'b0, res_dat},  {16'b0, tf(mem[beat])});
                        chk($sformatf("rnd%0d beat%0d last", d, beat), {31'b0, res_last}, {31'b0, beat == BN - 1});
                    end else begin
                        chk($sformatf("rnd%0d extra beat", d), 32'(beat), 32'(BN - 1));
                    end
                    beat++;
                end else if (res_val) begin
                    held = 1'b1; hd = res_dat; hl = res_last; stalls++;
                end
                tick();
                cyc++;
                if (done) begin
                    got_done = 1'b1;
                    chk($sformatf("rnd%0d beats", d),   32'(beat), 32'(BN));
                    chk($sformatf("rnd%0d latency", d), 32'(cyc),  32'(BN + 1 + stalls));
                end
            end
            if (!got_done) chk($sformatf("rnd%0d done timeout", d), 32'd0, 32'd1);
            start = 1'b0;
            tick();
            chk($sformatf("rnd%0d idle after done", d), {31'b0, busy | done}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
